// File: rtl/dp_ctrl_pkg.sv
// Shared types and widths for the dot-product accumulation controller.
package dp_ctrl_pkg;

  localparam int ACC_W  = 32;              // accumulator / result width
  localparam int LEN_W  = 16;              // job length (chunk count) width
  localparam int DATA_W = 8;               // lane operand width
  localparam int PROD_W = 2 * DATA_W + 1;  // unsigned x signed lane product width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/dot_product_parallel.sv
// Combinational DEPTH-lane dot product: unsigned activations times signed
// weights, summed and sign-extended to the accumulator width.
// Lane l occupies bits [l*DATA_W +: DATA_W] of each operand bus.
module dot_product_parallel
  import dp_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH*DATA_W-1:0] i_a,
  input  logic [DEPTH*DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0] o_dp
);

  logic signed [PROD_W-1:0] w_prod [DEPTH];

  // Per-lane product; operands widened explicitly so the multiply is exact.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
    logic signed [PROD_W-1:0] w_a_ext;
    logic signed [PROD_W-1:0] w_b_ext;
    assign w_a_ext = {{(PROD_W-DATA_W){1'b0}}, i_a[gi*DATA_W +: DATA_W]};
    assign w_b_ext = {{(PROD_W-DATA_W){i_b[gi*DATA_W+DATA_W-1]}}, i_b[gi*DATA_W +: DATA_W]};
    assign w_prod[gi] = w_a_ext * w_b_ext;
  end

  // Adder tree (as a loop): sign-extend each lane product and sum.
  always_comb begin
    o_dp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_dp = o_dp + {{(ACC_W-PROD_W){w_prod[i][PROD_W-1]}}, w_prod[i]};
    end
  end

endmodule

// File: rtl/dp_accum_ctrl.sv
// Job controller around the parallel dot-product unit: accepts num_chunks
// chunks, accumulates their dot products with wrap-around and a sticky signed
// overflow flag, then presents the result until it is consumed.
module dp_accum_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     start,
  input  logic [LEN_W-1:0]         num_chunks,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DEPTH*DATA_W-1:0]  in_a,
  input  logic [DEPTH*DATA_W-1:0]  in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_res,
  output logic                     out_ovf
);

  state_t                 r_state;
  logic [LEN_W-1:0]       r_len;
  logic [LEN_W-1:0]       r_count;
  logic signed [ACC_W-1:0] r_acc;
  logic                   r_ovf;
  logic                   r_busy;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic signed [ACC_W-1:0] r_out_res;
  logic                   r_out_ovf;

  logic signed [ACC_W-1:0] w_dp;
  logic signed [ACC_W-1:0] w_sum;
  logic                   w_step_ovf;
  logic                   w_xfer;
  logic                   w_last;

  dot_product_parallel #(.DEPTH(DEPTH)) u_dot (
    .i_a  (in_a),
    .i_b  (in_b),
    .o_dp (w_dp)
  );

  assign w_sum      = r_acc + w_dp;
  // Signed overflow: both addends share a sign that the sum does not.
  assign w_step_ovf = (r_acc[ACC_W-1] == w_dp[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
  assign w_xfer     = in_valid && r_in_ready;
  assign w_last     = (r_count == r_len - 16'd1);

  // Controller FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clear) begin
      // Abort beats start and both handshakes.
      r_state     <= IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len   <= num_chunks;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            if (num_chunks == '0) begin
              // Empty job: result is zero and is offered immediately.
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_out_res   <= '0;
              r_out_ovf   <= 1'b0;
            end else begin
              r_state    <= ACCUM;
              r_in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (w_xfer) begin
            r_acc   <= w_sum;
            r_count <= r_count + 16'd1;
            r_ovf   <= r_ovf | w_step_ovf;
            if (w_last) begin
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_res   <= w_sum;
              r_out_ovf   <= r_ovf | w_step_ovf;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
            r_out_ovf   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_dp_accum_ctrl.sv
// Directed bench for dp_accum_ctrl with a result scoreboard.
module tb_dp_accum_ctrl;

  localparam int DEPTH = 4;
  localparam int BW    = DEPTH * 8;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          start;
  logic [15:0]   num_chunks;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_res;
  logic          out_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] sb_q[$];   // {ovf, res}

  dp_accum_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .start      (start),
    .num_chunks (num_chunks),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_ovf    (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference dot product: lane l is bits [8l +: 8], a unsigned, b signed.
  function automatic longint model_dp(logic [BW-1:0] a, logic [BW-1:0] b);
    longint s = 0;
    for (int l = 0; l < DEPTH; l++) begin
      logic [7:0] la;
      logic [7:0] lb;
      int av;
      int bv;
      la = a[8*l +: 8];
      lb = b[8*l +: 8];
      av = int'(la);
      bv = int'($signed(lb));
      s  = s + longint'(av * bv);
    end
    return s;
  endfunction

  // mode 0: a=1..DEPTH, b=1; mode 1: a=255, b=127; mode 2: random lanes.
  task automatic run_job(input int n, input int mode, input bit gaps, input int hold, input string tag);
    logic [BW-1:0] qa[$];
    logic [BW-1:0] qb[$];
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic signed [31:0] m_acc;
    longint exact;
    bit m_ovf;
    logic [32:0] exp;
    int idx;
    int cyc;
    bit xfer;
    m_acc = 0;
    m_ovf = 0;
    for (int i = 0; i < n; i++) begin
      if (mode == 0) begin
        for (int l = 0; l < DEPTH; l++) begin
          a[8*l +: 8] = 8'(l + 1);
          b[8*l +: 8] = 8'd1;
        end
      end else if (mode == 1) begin
        a = {DEPTH{8'd255}};
        b = {DEPTH{8'd127}};
      end else begin
        a = BW'($urandom);
        b = BW'($urandom);
      end
      qa.push_back(a);
      qb.push_back(b);
      exact = longint'(m_acc) + model_dp(a, b);
      if (exact > 64'sd2147483647 || exact < -64'sd2147483648) m_ovf = 1;
      m_acc = exact[31:0];
    end
    sb_q.push_back({m_ovf, m_acc});

    start = 1; num_chunks = 16'(n);
    tick();
    start = 0;
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_in_ready_start"}, in_ready, (n > 0));

    idx = 0; cyc = 0;
    while (idx < n && cyc < 4 * n + 50) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 0;
      end else begin
        in_valid = 1; in_a = qa[idx]; in_b = qb[idx];
      end
      xfer = in_valid && in_ready;
      tick();
      if (xfer) idx++;
      cyc++;
    end
    in_valid = 0;
    check({tag, "_chunks_sent"}, idx, n);
    check({tag, "_out_valid_latency"}, out_valid, 1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin tick(); cyc++; end

    exp = sb_q.pop_front();
    check({tag, "_out_res"}, out_res, exp[31:0]);
    check({tag, "_out_ovf"}, out_ovf, exp[32]);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_res"}, out_res, exp[31:0]);
      check({tag, "_hold_ovf"}, out_ovf, exp[32]);
    end

    // Consume the result; a start in the same cycle must be ignored.
    out_ready = 1; start = 1; num_chunks = 16'd5;
    tick();
    out_ready = 0; start = 0;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_valid"}, out_valid, 0);
    check({tag, "_idle_res"}, out_res, 0);
    check({tag, "_idle_ovf"}, out_ovf, 0);
    tick();
    check({tag, "_start_ignored"}, busy, 0);
    $display("job %s: n=%0d res=%0h ovf=%0d", tag, n, out_res, exp[32]);
  endtask

  initial begin
    rst = 0; clear = 0; start = 0; num_chunks = 0;
    in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;

    #2 rst = 1;
    #1;
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_res", out_res, 0);
    check("reset_out_ovf", out_ovf, 0);
    tick();
    rst = 0;
    tick();

    run_job(3, 0, 0, 0, "basic30");
    run_job(0, 0, 0, 0, "empty");
    run_job(2, 2, 1, 5, "gaps_hold");
    run_job(4, 2, 1, 2, "random");
    run_job(2200, 1, 0, 1, "max2200");
    run_job(17000, 1, 0, 1, "overflow");

    // Clear together with start: nothing begins.
    start = 1; clear = 1; num_chunks = 16'd5;
    tick();
    start = 0; clear = 0;
    check("clr_start_busy", busy, 0);
    check("clr_start_in_ready", in_ready, 0);
    $display("clear with start: busy=%0d", busy);

    // Clear mid-ACCUM after two chunks, with a handshake pending.
    start = 1; num_chunks = 16'd6;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_a = BW'($urandom); in_b = BW'($urandom);
      if (i == 2) clear = 1;
      tick();
    end
    clear = 0; in_valid = 0;
    check("clr_mid_busy", busy, 0);
    check("clr_mid_in_ready", in_ready, 0);
    check("clr_mid_out_valid", out_valid, 0);
    $display("clear mid-job: busy=%0d", busy);
    run_job(3, 0, 0, 0, "after_clear");

    // Asynchronous reset between edges in ACCUM.
    start = 1; num_chunks = 16'd4;
    tick();
    start = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_a = {DEPTH{8'd9}}; in_b = {DEPTH{8'd3}};
      tick();
    end
    in_valid = 0;
    #2 rst = 1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_res", out_res, 0);
    check("arst_out_ovf", out_ovf, 0);
    $display("async reset mid-job: busy=%0d in_ready=%0d", busy, in_ready);
    tick();
    rst = 0;
    tick();
    run_job(3, 0, 0, 0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
